// File: rtl/c3lib_hs4_rcv.sv
// Four-phase bundled-data handshake receiver: synchronizes req_in into clk,
// captures data_in into a one-entry valid/ready buffer and returns ack_out.
//   state    | meaning
//   IDLE     | ack low, waiting for synchronized request and buffer space
//   WAIT_LOW | word captured, ack high, waiting for request return-to-zero
module c3lib_hs4_rcv #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_out,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, WAIT_LOW = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   pop;
  logic                   space;
  logic                   capture;
  logic                   ack_q, ack_d;
  logic                   vld_q, vld_d;
  logic [WIDTH-1:0]       dout_q, dout_d;

  // req_in is only ever sampled by the first stage of this chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign pop   = vld_q & dout_rdy;
  assign space = ~vld_q | dout_rdy;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && space) begin
          capture = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d  = (state_d == WAIT_LOW);
    vld_d  = capture | (vld_q & ~pop);
    dout_d = capture ? data_in : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
    end
  end

  assign ack_out  = ack_q;
  assign dout_vld = vld_q;
  assign dout     = dout_q;
  assign busy     = (state_q == WAIT_LOW);

endmodule

// File: tb/tb_c3lib_hs4_rcv.sv
// Bench for c3lib_hs4_rcv: vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference model of the handshake rules.
module tb_c3lib_hs4_rcv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req1 = 1'b0, rdy1 = 1'b0, ack1, vld1, busy1;
  logic [W-1:0] data1 = '0, dout1;
  logic         req2 = 1'b0, rdy2 = 1'b0, ack2, vld2, busy2;
  logic [W-1:0] data2 = '0, dout2;

  always #5 clk = ~clk;

  c3lib_hs4_rcv #(.WIDTH(W), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_in(req1), .data_in(data1), .ack_out(ack1),
    .dout(dout1), .dout_vld(vld1), .dout_rdy(rdy1), .busy(busy1));

  c3lib_hs4_rcv #(.WIDTH(W), .SYNC_STAGES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_in(req2), .data_in(data2), .ack_out(ack2),
    .dout(dout2), .dout_vld(vld2), .dout_rdy(rdy2), .busy(busy2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req1 = 1'b0; req2 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         req;
    logic [W-1:0] data;
    logic         rdy;
    logic         ack;
    logic         vld;
    logic         busy;
    logic [W-1:0] dout;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [W-1:0] d, input logic y,
                     input logic a, input logic v, input logic b, input logic [W-1:0] o);
    vec_t e;
    e.req = r; e.data = d; e.rdy = y; e.ack = a; e.vld = v; e.busy = b; e.dout = o;
    vq.push_back(e);
  endtask

  // reference model state: req history (index 0 newest), handshake flag, buffer
  bit           hist[2];
  bit           m_hs, m_vld;
  logic [W-1:0] m_dout;

  initial begin
    int sent, nrx, last, caps, nvld, nbusy_lo;
    logic [W-1:0] a5;
    a5 = 32'hA5A5_1234;

    // basic transfer, then backpressure (one row per clock edge)
    add(1, a5, 1, 0, 0, 0, 0);
    add(1, a5, 1, 0, 0, 0, 0);
    add(1, a5, 1, 1, 1, 1, a5);
    add(0, a5, 1, 1, 0, 1, a5);
    add(0, a5, 1, 1, 0, 1, a5);
    add(0, a5, 1, 0, 0, 0, a5);
    add(1, 1, 0, 0, 0, 0, a5);
    add(1, 1, 0, 0, 0, 0, a5);
    add(1, 1, 0, 1, 1, 1, 1);
    add(0, 1, 0, 1, 1, 1, 1);
    add(0, 1, 0, 1, 1, 1, 1);
    add(0, 1, 0, 0, 1, 0, 1);
    add(1, 2, 0, 0, 1, 0, 1);
    add(1, 2, 0, 0, 1, 0, 1);
    add(1, 2, 0, 0, 1, 0, 1);
    add(1, 2, 0, 0, 1, 0, 1);
    add(1, 2, 1, 1, 1, 1, 2);
    add(0, 2, 0, 1, 1, 1, 2);
    add(0, 2, 0, 1, 1, 1, 2);
    add(0, 2, 1, 0, 0, 0, 2);

    do_reset();
    chk("reset_s2", {ack1, vld1, busy1, dout1}, 64'd0);
    chk("reset_s3", {ack2, vld2, busy2, dout2}, 64'd0);

    foreach (vq[i]) begin
      req1 = vq[i].req; data1 = vq[i].data; rdy1 = vq[i].rdy;
      tick();
      chk($sformatf("vec%0d", i), {ack1, vld1, busy1, dout1},
          {vq[i].ack, vq[i].vld, vq[i].busy, vq[i].dout});
    end

    // back-to-back stream with a zero-delay transmitter
    do_reset();
    rdy1 = 1'b1;
    sent = 0; nrx = 0; last = -1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (!ack1 && !req1 && sent < 8) begin
        req1 = 1'b1; data1 = 32'(sent); sent++;
      end else if (ack1 && req1) begin
        req1 = 1'b0;
      end
      tick();
      if (vld1) begin
        chk($sformatf("stream_word%0d", nrx), dout1, 64'(nrx));
        if (nrx > 0) chk($sformatf("stream_period%0d", nrx), 64'(cyc - last), 64'd6);
        last = cyc;
        nrx++;
      end
    end
    chk("stream_count", 64'(nrx), 64'd8);

    // runt request on the 3-stage instance
    do_reset();
    rdy2 = 1'b1; data2 = 32'hCAFE_0003; req2 = 1'b1;
    tick();
    req2 = 1'b0;
    caps = 0;
    repeat (12) begin
      tick();
      if (vld2) begin
        caps++;
        chk("runt_word", dout2, 64'(32'hCAFE_0003));
      end
    end
    chk("runt_at_most_one", 64'(caps <= 1), 64'd1);
    chk("runt_idle", {ack2, busy2}, 64'd0);

    // asynchronous reset in the middle of a handshake
    do_reset();
    rdy1 = 1'b0; data1 = 32'hDEAD_BEEF; req1 = 1'b1;
    repeat (3) tick();
    chk("pre_reset_wait_low", {ack1, vld1, busy1, dout1}, {3'b111, 32'hDEAD_BEEF});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clear", {ack1, vld1, busy1, dout1}, 64'd0);
    data1 = 32'h1357_9BDF;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset_no_early_cap", {ack1, vld1}, 64'd0);
    tick();
    chk("post_reset_capture", {ack1, vld1, busy1, dout1}, {3'b111, 32'h1357_9BDF});

    // request held high: no second capture, busy stays high
    rdy1 = 1'b1;
    nvld = 0; nbusy_lo = 0;
    repeat (50) begin
      tick();
      if (vld1) nvld++;
      if (!busy1) nbusy_lo++;
    end
    chk("stable_high_extra_vld", 64'(nvld), 64'd0);
    chk("stable_high_busy_drop", 64'(nbusy_lo), 64'd0);
    chk("stable_high_dout", dout1, 64'(32'h1357_9BDF));

    // randomized transmitter/consumer against the reference model
    do_reset();
    hist[0] = 0; hist[1] = 0; m_hs = 0; m_vld = 0; m_dout = '0;
    for (int i = 0; i < 600; i++) begin
      bit req_s, space;
      rdy1 = ($urandom_range(0, 3) != 0);
      if (!req1 && !ack1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; data1 = $urandom;
      end else if (req1 && ack1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b0;
      end else if (req1 && !ack1 && $urandom_range(0, 15) == 0) begin
        req1 = 1'b0;
      end
      req_s = hist[1];
      space = !m_vld || rdy1;
      if (!m_hs && req_s && space) begin
        m_dout = data1; m_vld = 1; m_hs = 1;
      end else begin
        if (m_vld && rdy1) m_vld = 0;
        if (m_hs && !req_s) m_hs = 0;
      end
      hist[1] = hist[0];
      hist[0] = req1;
      tick();
      chk($sformatf("rand%0d", i), {ack1, vld1, busy1, dout1}, {m_hs, m_vld, m_hs, m_dout});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c3lib_hs4_rcv.md
# c3lib_hs4_rcv

Receiver end of a four-phase, bundled-data request/acknowledge handshake crossing into the `clk` domain. It synchronizes an asynchronous `req_in`, captures a WIDTH-bit `data_in` held stable by the transmitter, and returns `ack_out`. It presents the captured word to local logic through a one-entry valid/ready buffer. It sits in the c3lib primitive layer as the counterpart of the four-phase transmitter, for sideband/configuration transfers between unrelated clock domains.

## Interface
- WIDTH, 32, data bus width (>=1)
- SYNC_STAGES, 2, synchronizer depth on `req_in` (>=2)
- clk  in  1  receive-domain clock
- rst_n  in  1  reset, asynchronous, active-low; clock clk
- req_in  in  1  request from transmitter domain; asynchronous to clk
- data_in  in  WIDTH  bundled data; stable from `req_in` rise until `ack_out` rise is observed by the transmitter
- ack_out  out  1  acknowledge to transmitter; registered, glitch-free
- dout  out  WIDTH  captured word
- dout_vld  out  1  `dout` holds an unconsumed word
- dout_rdy  in  1  local consumer accepts `dout` when `dout_vld & dout_rdy`
- busy  out  1  handshake in progress (state WAIT_LOW)

## Operation
- `req_in` passes through a SYNC_STAGES flop chain; the last stage is `req_s`. All chain flops reset to 0. No other logic samples `req_in` directly.
- pop = `dout_vld & dout_rdy`; space = `!dout_vld | dout_rdy`.
- FSM, two states, reset to IDLE:
  - IDLE: `ack_out`=0. If `req_s`=1 and space: load `dout` <= `data_in`, set `dout_vld`=1, set `ack_out`=1, go to WAIT_LOW. If `req_s`=1 and no space: stay, no capture, `ack_out` stays 0 (backpressure to the transmitter).
  - WAIT_LOW: `ack_out`=1. If `req_s`=0: `ack_out`<=0, go to IDLE. Otherwise hold.
- `dout_vld` clears on pop unless a capture occurs in the same cycle; a capture plus pop in the same cycle leaves `dout_vld`=1 with the new word.
- `dout` changes only on capture and holds its value otherwise, including after pop.
- `busy` = (state == WAIT_LOW), combinational from the state register.
- A new capture requires a full return-to-zero of `req_s` first. One transfer per four-phase cycle; there is no double capture while `req_s` stays high.
- Protocol violation (`req_in` falls before `ack_out` rises): if `req_s` falls before the capture edge, nothing is captured. If it falls after, the transfer completes normally and WAIT_LOW exits on the next `req_s`=0.

## Timing
- Reset values: `ack_out`=0, `dout_vld`=0, `dout`=0, `busy`=0, state IDLE, sync chain all 0. Reset assertion clears all of them asynchronously, including mid-handshake. The transmitter then sees `ack_out` fall and must restart from `req_in`=0.
- Forward latency: if `req_in` is first sampled high at clk edge E, `req_s`=1 after edge E+SYNC_STAGES-1. Capture, `dout_vld`=1 and `ack_out`=1 occur at edge E+SYNC_STAGES (buffer space present).
- Return latency: `req_in` first sampled low at edge F gives `ack_out`=0 and `busy`=0 at edge F+SYNC_STAGES.
- `data_in` is sampled only on the capture edge. The transmitter's hold requirement (data stable until `ack_out` is seen high) guarantees a settled value at that edge; no synchronizer is used on `data_in`.
- Backpressure: a capture blocked by a full buffer proceeds on the first edge where space=1, i.e. the same edge as the pop.
- Minimum transfer period, with an immediately consuming sink and a zero-delay transmitter: 2*SYNC_STAGES+2 clk cycles per word.

## Test plan
- Basic transfer (WIDTH=32, SYNC_STAGES=2, `dout_rdy`=1): drive `data_in`=0xA5A5_1234, raise `req_in` before edge 0 -> `dout`=0xA5A5_1234, `dout_vld`=1 and `ack_out`=1 at edge 2. Drop `req_in` -> `ack_out`=0 two edges later; `dout_vld` clears one cycle after capture.
- Backpressure: hold `dout_rdy`=0 with word 0x1 buffered, send 0x2 -> `ack_out` stays 0 and `dout` stays 0x1. Assert `dout_rdy` for 1 cycle -> 0x1 popped and 0x2 captured on the same edge, `dout_vld` stays 1, `ack_out` rises.
- Back-to-back stream: 8 transfers 0x0..0x7 with a transmitter that responds in zero time -> all 8 words appear in order, none dropped or duplicated, and each transfer spans 6 cycles.
- Runt request: pulse `req_in` high for 1 clk cycle (SYNC_STAGES=3) -> either no capture or exactly one capture followed by a return to IDLE; never two captures.
- Reset mid-operation: assert `rst_n`=0 while in WAIT_LOW with `dout_vld`=1 -> `ack_out`, `dout_vld`, `busy` and `dout` are 0 immediately. After release with `req_in` held high, a fresh capture occurs SYNC_STAGES edges later.
- Stable-high request: hold `req_in`=1 for 50 cycles after capture -> exactly one `dout_vld` pulse and `busy`=1 throughout.
